call_loop: RTL and testbench

Parametrised iterated-call controller: accepts `a`, `b` and an iteration count, then invokes an external two-operand callee `count` times through a start/done handshake, feeding each result back as the next first operand (acc = g(acc, b)). It is the generalised successor of the single-call wrapper. It adds configurable data width, a runtime loop count, single-cycle call pulses and an optional callee timeout with error reporting. It sits between a caller FSM and any callee that uses the standard start/done/result protocol.

---
 rtl/call_loop.sv | 154 +++++++++++++++
 tb/tb_call_loop.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/call_loop.sv
`default_nettype none
// ==========================================================================
// call_loop : repeated start/done callee invocation, acc = g(acc, b)
// Rev 1.0
// ==========================================================================
module call_loop #(
  parameter int WIDTH   = 32,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [CNT_W-1:0] count_i,
  output logic [WIDTH-1:0] result_o,
  output logic             done_o,
  output logic             err_o,
  output logic             busy_o,
  output logic             call_start_o,
  output logic [WIDTH-1:0] call_a_o,
  output logic [WIDTH-1:0] call_b_o,
  input  logic             call_done_i,
  input  logic [WIDTH-1:0] call_result_i
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_CHECK  = 3'd2,
    S_CALL   = 3'd3,
    S_WAIT   = 3'd4,
    S_FINISH = 3'd5
  } state_e;

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] call_a_q, call_a_d;
  logic [WIDTH-1:0] call_b_q, call_b_d;
  logic [CNT_W-1:0] rem_q,    rem_d;
  logic [TW-1:0]    wcnt_q,   wcnt_d;
  logic             done_q,   done_d;
  logic             err_q,    err_d;
  logic             timeout_hit;

  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      logic unused_wcnt;
      assign unused_wcnt = ^wcnt_q;
      assign timeout_hit = 1'b0;
    end else begin : g_timeout
      localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);
      assign timeout_hit = (wcnt_q == LAST);
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      result_q <= '0;
      call_a_q <= '0;
      call_b_q <= '0;
      rem_q    <= '0;
      wcnt_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      call_a_q <= call_a_d;
      call_b_q <= call_b_d;
      rem_q    <= rem_d;
      wcnt_q   <= wcnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result_q;
    call_a_d = call_a_q;
    call_b_d = call_b_q;
    rem_d    = rem_q;
    wcnt_d   = wcnt_q;
    done_d   = done_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_LATCH;
      end
      S_LATCH: begin
        acc_d    = a_i;
        call_b_d = b_i;
        rem_d    = count_i;
        done_d   = 1'b0;
        err_d    = 1'b0;
        state_d  = S_CHECK;
      end
      S_CHECK: begin
        if (rem_q == '0) begin
          state_d = S_FINISH;
        end else begin
          // Load operand on the way into CALL so it is already valid
          // in the cycle call_start is high.
          call_a_d = acc_q;
          state_d  = S_CALL;
        end
      end
      S_CALL: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (call_done_i) begin
          acc_d   = call_result_i;
          rem_d   = rem_q - 1'b1;
          state_d = S_CHECK;
        end else if (timeout_hit) begin
          result_d = acc_q;
          err_d    = 1'b1;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_FINISH: begin
        result_d = acc_q;
        done_d   = 1'b1;
        err_d    = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign result_o     = result_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign busy_o       = (state_q != S_IDLE);
  assign call_start_o = (state_q == S_CALL);
  assign call_a_o     = call_a_q;
  assign call_b_o     = call_b_q;

endmodule
`default_nettype wire

// File: tb/tb_call_loop.sv
`default_nettype none
// tb_call_loop : randomized and directed checks of call_loop against a
// closed-form model (result = a + n*b, call k at cycle 3+k(L+2)).
module tb_call_loop;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a_in, b_in;
  logic [7:0]  cnt_in;
  logic [31:0] result;
  logic        done, err, busy, call_start;
  logic [31:0] call_a, call_b;
  logic        call_done;
  logic [31:0] call_result;

  int n_checks = 0;
  int n_fail   = 0;
  bit prev_done = 1'b0;

  always #5 clk = ~clk;

  call_loop #(.WIDTH(32), .CNT_W(8), .TIMEOUT(TO)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .a_i          (a_in),
    .b_i          (b_in),
    .count_i      (cnt_in),
    .result_o     (result),
    .done_o       (done),
    .err_o        (err),
    .busy_o       (busy),
    .call_start_o (call_start),
    .call_a_o     (call_a),
    .call_b_o     (call_b),
    .call_done_i  (call_done),
    .call_result_i(call_result)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      start     = 1'b0;
      call_done = 1'b0;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_call_start", call_start, 0);
      chk("idle_done", done, prev_done);
    end
  endtask

  // Called at a negedge; that negedge is cycle 0 (start is driven there).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int n,
                        input int lat, input int hang_at, input int pulse_at,
                        input int rst_at, input bit spur);
    int          per, ncalls, done_exp, calls_seen, pend_c, k;
    bit          hang, pend, exp_cs, exp_busy, exp_done;
    logic [31:0] exp_res, exp_a, pend_r;
    per        = lat + 2;
    hang       = (hang_at >= 0);
    calls_seen = 0;
    pend       = 1'b0;
    pend_c     = 0;
    pend_r     = '0;
    if (hang) begin
      ncalls   = hang_at + 1;
      done_exp = 3 + hang_at * per + TO + 1;
      exp_res  = a + 32'(hang_at) * b;
    end else begin
      ncalls   = n;
      done_exp = 4 + n * per;
      exp_res  = a + 32'(n) * b;
    end
    for (int c = 0; c <= done_exp; c++) begin
      exp_cs   = (c >= 3) && ((c - 3) % per == 0) && ((c - 3) / per < ncalls) && (c < done_exp);
      exp_busy = (c >= 1) && (c < done_exp);
      exp_done = (c < 2) ? prev_done : (c >= done_exp);
      chk("busy", busy, exp_busy);
      chk("call_start", call_start, exp_cs);
      chk("done", done, exp_done);
      if (exp_cs) begin
        k     = (c - 3) / per;
        exp_a = a + 32'(k) * b;
        chk("call_a", call_a, exp_a);
        chk("call_b", call_b, b);
      end
      if (c == done_exp) begin
        chk("result", result, exp_res);
        chk("err", err, hang);
        prev_done = 1'b1;
        return;
      end
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_result", result, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_call_start", call_start, 0);
        chk("rst_call_a", call_a, 0);
        chk("rst_call_b", call_b, 0);
        prev_done = 1'b0;
        start     = 1'b0;
        call_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(8);
        return;
      end
      start = (c == 0) || (c == pulse_at);
      if (c == 0) begin
        a_in   = a;
        b_in   = b;
        cnt_in = 8'(n);
      end else if (c == pulse_at) begin
        a_in   = $urandom;
        b_in   = $urandom;
        cnt_in = 8'($urandom);
      end
      call_done   = 1'b0;
      call_result = $urandom;
      if (call_start) begin
        if (calls_seen != hang_at) begin
          pend   = 1'b1;
          pend_c = c + lat;
          pend_r = call_a + call_b;
        end
        calls_seen++;
        if (spur) call_done = 1'b1;
      end
      if (pend && c == pend_c) begin
        call_done   = 1'b1;
        call_result = pend_r;
        pend        = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int n, lat, hang_at, pulse_at;
    rst_n       = 1'b0;
    start       = 1'b0;
    a_in        = '0;
    b_in        = '0;
    cnt_in      = '0;
    call_done   = 1'b0;
    call_result = '0;
    repeat (2) @(negedge clk);
    chk("init_result", result, 0);
    chk("init_done", done, 0);
    chk("init_busy", busy, 0);
    chk("init_call_a", call_a, 0);
    rst_n = 1'b1;
    idle(2);

    run_op(32'd5, 32'd3, 4, 1, -1, -1, -1, 1'b0);
    idle(2);
    run_op(32'hDEADBEEF, 32'd9, 0, 1, -1, -1, -1, 1'b0);
    idle(1);
    run_op(32'hFFFFFFFF, 32'd1, 1, 3, -1, -1, -1, 1'b0);
    idle(1);
    run_op(32'd7, 32'd4, 2, 1, 0, -1, -1, 1'b0);
    idle(3);
    run_op(32'd1, 32'd1, 3, 2, -1, 5, -1, 1'b1);
    run_op(32'd10, 32'd2, 1, 1, -1, -1, -1, 1'b0);
    idle(1);
    run_op(32'd1, 32'd1, 3, 2, -1, -1, 6, 1'b0);

    for (int r = 0; r < 25; r++) begin
      n       = int'($urandom_range(0, 5));
      lat     = int'($urandom_range(1, 8));
      hang_at = (n > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      pulse_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 5)) : -1;
      run_op($urandom, $urandom, n, lat, hang_at, pulse_at, -1, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
